// File: rtl/binary_to_bcd_converter.sv
// binary_to_bcd_converter: sequential double-dabble converter, one shift per clock, start/done handshake
module binary_to_bcd_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clock,
   input  logic                  reset_N,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = 4 * DIGITS;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] sr;
   logic [AW-1:0] acc, adj;
   logic [CW-1:0] cnt;
   logic sticky;
   logic [AW+WIDTH:0] sh;
   logic accept, last;
   assign accept = start && state != SHIFT;
   assign last   = state == SHIFT && cnt == CW'(1);
   always_comb begin
      adj = acc;
      for (int i = 0; i < DIGITS; i++)
         adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
   end
   // sh[AW+WIDTH] is the bit leaving the top digit; it feeds the sticky overflow
   assign sh = {adj, sr, 1'b0};
   always_ff @(posedge clock or negedge reset_N)
      if (!reset_N) state <= IDLE;
      else          state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? SHIFT : IDLE;
         SHIFT:   state_nx = last ? DONE : SHIFT;
         DONE:    state_nx = start ? SHIFT : IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      busy = state == SHIFT;
      done = state == DONE;
   end
   always_ff @(posedge clock or negedge reset_N)
      if (!reset_N) begin
         sr       <= '0;
         acc      <= '0;
         cnt      <= '0;
         sticky   <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
      end else if (accept) begin
         sr     <= bin;
         acc    <= '0;
         cnt    <= CW'(WIDTH);
         sticky <= 1'b0;
      end else if (state == SHIFT) begin
         sr     <= sh[WIDTH-1:0];
         acc    <= sh[AW+WIDTH-1 -: AW];
         cnt    <= cnt - CW'(1);
         sticky <= sticky | sh[AW+WIDTH];
         if (last) begin
            bcd_out  <= sh[AW+WIDTH-1 -: AW];
            overflow <= sticky | sh[AW+WIDTH];
         end
      end
endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// tb_binary_to_bcd_converter: directed checks of the converter, default and two-digit instances
module tb_binary_to_bcd_converter;
   logic clock = 1'b0;
   logic reset_N = 1'b0;
   logic start = 1'b0, start2 = 1'b0;
   logic [7:0] bin = '0, bin2 = '0;
   logic busy, done, overflow, busy2, done2, overflow2;
   logic [11:0] bcd_out;
   logic [7:0] bcd2;
   int passed = 0, total = 0;

   always #5 clock = ~clock;

   binary_to_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
      .clock(clock), .reset_N(reset_N), .start(start), .bin(bin),
      .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow));

   binary_to_bcd_converter #(.WIDTH(8), .DIGITS(2)) dut2 (
      .clock(clock), .reset_N(reset_N), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(overflow2));

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: seg7 = 7'h3f; 4'd1: seg7 = 7'h06; 4'd2: seg7 = 7'h5b; 4'd3: seg7 = 7'h4f;
         4'd4: seg7 = 7'h66; 4'd5: seg7 = 7'h6d; 4'd6: seg7 = 7'h7d; 4'd7: seg7 = 7'h07;
         4'd8: seg7 = 7'h7f; 4'd9: seg7 = 7'h6f; default: seg7 = 7'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (busy && n < 20) begin
         n++;
         tick();
      end
   endtask

   task automatic run(input logic [7:0] v, input logic [11:0] eb, input logic eo, input string tag);
      int n;
      start = 1'b1; bin = v;
      tick();
      start = 1'b0;
      wait_busy(n);
      chk({tag, " busy_cycles"}, 32'(n), 32'd8);
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " bcd"}, 32'(bcd_out), 32'(eb));
      chk({tag, " ovf"}, 32'(overflow), 32'(eo));
      tick();
      chk({tag, " done_once"}, 32'(done), 32'd0);
   endtask

   task automatic run2(input logic [7:0] v, input logic [7:0] eb, input logic eo, input string tag);
      int n;
      start2 = 1'b1; bin2 = v;
      tick();
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 20) begin
         n++;
         tick();
      end
      chk({tag, " latency"}, 32'(n), 32'd8);
      chk({tag, " bcd"}, 32'(bcd2), 32'(eb));
      chk({tag, " ovf"}, 32'(overflow2), 32'(eo));
   endtask

   initial begin
      int n, pulses;
      #12;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset bcd", 32'(bcd_out), 32'd0);
      chk("reset ovf", 32'(overflow), 32'd0);
      reset_N = 1'b1;
      tick();
      run(8'd0,   12'h000, 1'b0, "bin0");
      run(8'd255, 12'h255, 1'b0, "bin255");
      run(8'd99,  12'h099, 1'b0, "bin99");
      run(8'd200, 12'h200, 1'b0, "bin200");
      // start mid-conversion must be ignored
      start = 1'b1; bin = 8'd37;
      tick();
      start = 1'b0;
      tick(); tick();
      start = 1'b1; bin = 8'd250;
      tick();
      start = 1'b0;
      chk("ignore busy", 32'(busy), 32'd1);
      wait_busy(n);
      chk("ignore cycles", 32'(n), 32'd5);
      chk("ignore done", 32'(done), 32'd1);
      chk("ignore bcd", 32'(bcd_out), 32'h037);
      start = 1'b1; bin = 8'd142;
      tick();
      start = 1'b0;
      chk("b2b busy", 32'(busy), 32'd1);
      chk("b2b done_once", 32'(done), 32'd0);
      wait_busy(n);
      chk("b2b cycles", 32'(n), 32'd8);
      chk("b2b done", 32'(done), 32'd1);
      chk("b2b bcd", 32'(bcd_out), 32'h142);
      tick();
      run2(8'd100, 8'h00, 1'b1, "d2_100");
      run2(8'd255, 8'h55, 1'b1, "d2_255");
      run2(8'd99,  8'h99, 1'b0, "d2_99");
      run2(8'd200, 8'h00, 1'b1, "d2_200");
      tick();
      // asynchronous reset in the middle of a conversion
      start = 1'b1; bin = 8'd180;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("pre_rst busy", 32'(busy), 32'd1);
      #2 reset_N = 1'b0;
      #1;
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst done", 32'(done), 32'd0);
      chk("arst bcd", 32'(bcd_out), 32'd0);
      chk("arst ovf", 32'(overflow), 32'd0);
      chk("arst ovf2", 32'(overflow2), 32'd0);
      tick();
      reset_N = 1'b1;
      pulses = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (done || busy) pulses++;
      end
      chk("post_rst quiet", 32'(pulses), 32'd0);
      chk("post_rst bcd", 32'(bcd_out), 32'd0);
      // ones digit through a seven-segment decoder for every input value
      for (int v = 0; v < 256; v++) begin
         start = 1'b1; bin = 8'(v);
         tick();
         start = 1'b0;
         wait_busy(n);
         chk("sweep done", 32'(done), 32'd1);
         chk("sweep ones", 32'(bcd_out[3:0]), 32'(v % 10));
         chk("sweep seg", 32'(seg7(bcd_out[3:0]) == 7'h00), 32'd0);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
